// File: rtl/seg_scan_driver.sv
// seg_scan_driver: serial BCD conversion and 6-digit multiplexed 7-segment scan with blanking, sign and points
// Ports:
//   sys_clk  system clock
//   sys_rst  asynchronous reset, active-high
//   data     unsigned binary value, clamped to DATA_MAX
//   point    per-digit decimal point, active-high, bit 0 = rightmost digit
//   seg_en   display enable, active-high
//   sign     show '-' to the left of the most significant shown digit
//   sel      digit select, active-low one-hot
//   seg      segments {dp,g,f,e,d,c,b,a}, active-low
module seg_scan_driver #(
    parameter logic [15:0] CNT_MAX  = 16'd24_999,
    parameter logic [19:0] DATA_MAX = 20'd999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        seg_en,
    input  logic        sign,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    logic [1:0]  state;
    logic [4:0]  bit_cnt;
    logic [19:0] bin;
    logic [23:0] bcd, bcd_adj, disp_bcd;
    logic [5:0]  cap_pt, disp_pt;
    logic        cap_sign, disp_sign;
    logic [15:0] cnt;
    logic [2:0]  idx, m;
    logic [3:0]  nib;
    logic [7:0]  dec, seg_nxt;
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bin       <= '0;
            bcd       <= '0;
            cap_pt    <= '0;
            cap_sign  <= 1'b0;
            disp_bcd  <= '0;
            disp_pt   <= '0;
            disp_sign <= 1'b0;
        end else begin
            case (state)
                IDLE: if (seg_en) begin
                    bin      <= data > DATA_MAX ? DATA_MAX : data;
                    bcd      <= '0;
                    bit_cnt  <= '0;
                    cap_pt   <= point;
                    cap_sign <= sign;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[22:0], bin, 1'b0};
                    bit_cnt    <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd19) state <= DONE;
                end
                DONE: begin
                    disp_bcd  <= bcd;
                    disp_pt   <= cap_pt;
                    disp_sign <= cap_sign;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // m: highest digit that must be drawn (nonzero value or lit point), at least digit 0
    always_comb begin
        m = '0;
        for (int i = 1; i < 6; i++)
            if (disp_bcd[4*i +: 4] != 4'd0 || disp_pt[i]) m = 3'(i);
    end
    always_comb begin
        nib = disp_bcd[4*idx +: 4];
        case (nib)
            4'd0:    dec = 8'hC0;
            4'd1:    dec = 8'hF9;
            4'd2:    dec = 8'hA4;
            4'd3:    dec = 8'hB0;
            4'd4:    dec = 8'h99;
            4'd5:    dec = 8'h92;
            4'd6:    dec = 8'h82;
            4'd7:    dec = 8'hF8;
            4'd8:    dec = 8'h80;
            4'd9:    dec = 8'h90;
            default: dec = 8'hFF;
        endcase
        // m+1 is 6 when all digits are used, which no index reaches, so the sign drops out
        seg_nxt = idx <= m ? dec & {~disp_pt[idx], 7'h7F} :
                  (disp_sign && idx == m + 3'd1) ? 8'hBF : 8'hFF;
    end
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt <= '0;
            idx <= '0;
            sel <= 6'h3F;
            seg <= 8'hFF;
        end else if (!seg_en) begin
            cnt <= '0;
            idx <= '0;
            sel <= 6'h3F;
            seg <= 8'hFF;
        end else begin
            cnt <= cnt == CNT_MAX ? 16'd0 : cnt + 16'd1;
            if (cnt == CNT_MAX) idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
            sel <= ~(6'd1 << idx);
            seg <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of conversion latency, digit content, enable and reset behaviour
module tb_seg_scan_driver;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [19:0] data    = '0;
    logic [5:0]  point   = '0;
    logic        seg_en  = 1'b0;
    logic        sign    = 1'b0;
    logic [5:0]  sel;
    logic [7:0]  seg;
    int tests = 0;
    int fails = 0;

    seg_scan_driver #(.CNT_MAX(16'd4), .DATA_MAX(20'd999_999)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data(data), .point(point),
        .seg_en(seg_en), .sign(sign), .sel(sel), .seg(seg)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_sel(input int k);
        int t = 0;
        logic [5:0] want;
        want = ~(6'd1 << k);
        while (sel !== want && t < 60) begin
            @(negedge sys_clk);
            t++;
        end
        check($sformatf("sel_d%0d", k), {2'b0, sel}, {2'b0, want});
    endtask

    task automatic scan_check(input string tag, input logic [47:0] e);
        for (int k = 0; k < 6; k++) begin
            wait_sel(k);
            check($sformatf("%s_d%0d", tag, k), seg, e[8*k +: 8]);
        end
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_sel", {2'b0, sel}, 8'h3F);
        check("rst_seg", seg, 8'hFF);
        // 1: latency and first wrap
        sys_rst = 1'b0;
        seg_en  = 1'b1;
        data    = 20'd123456;
        repeat (22) @(negedge sys_clk);
        check("t1_pre_sel", {2'b0, sel}, 8'h2F);
        check("t1_pre_seg", seg, 8'hFF);
        @(negedge sys_clk);
        check("t1_lat_sel", {2'b0, sel}, 8'h2F);
        check("t1_lat_seg", seg, 8'hA4);
        repeat (3) @(negedge sys_clk);
        check("t1_d5_sel", {2'b0, sel}, 8'h1F);
        check("t1_d5_seg", seg, 8'hF9);
        repeat (5) @(negedge sys_clk);
        check("t1_wrap_sel", {2'b0, sel}, 8'h3E);
        check("t1_wrap_seg", seg, 8'h82);
        scan_check("t1", 48'hF9A4B0999282);
        // 2: sign next to a single digit
        data = 20'd7;
        sign = 1'b1;
        repeat (50) @(negedge sys_clk);
        scan_check("t2", 48'hFFFFFFFFBFF8);
        // 4: point extends the significant span
        data  = 20'd5;
        sign  = 1'b0;
        point = 6'b010000;
        repeat (50) @(negedge sys_clk);
        scan_check("t4", 48'hFF40C0C0C092);
        // 3: clamp, sign dropped with all six digits used
        data  = 20'd1_000_000;
        point = '0;
        sign  = 1'b1;
        repeat (50) @(negedge sys_clk);
        scan_check("t3", 48'h909090909090);
        // 5: disable at digit 3, re-enable at digit 0
        wait_sel(3);
        seg_en = 1'b0;
        @(negedge sys_clk);
        check("t5_off_sel", {2'b0, sel}, 8'h3F);
        check("t5_off_seg", seg, 8'hFF);
        repeat (10) @(negedge sys_clk);
        check("t5_hold_sel", {2'b0, sel}, 8'h3F);
        seg_en = 1'b1;
        @(negedge sys_clk);
        check("t5_on_sel", {2'b0, sel}, 8'h3E);
        check("t5_on_seg", seg, 8'h90);
        // 6: async reset mid-conversion, then input change mid-SHIFT
        repeat (8) @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        check("t6_rst_sel", {2'b0, sel}, 8'h3F);
        check("t6_rst_seg", seg, 8'hFF);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        sign    = 1'b0;
        data    = 20'd123456;
        repeat (5) @(negedge sys_clk);
        data = 20'd999;
        repeat (17) @(negedge sys_clk);
        check("t6_pre_seg", seg, 8'hFF);
        @(negedge sys_clk);
        check("t6_d4_sel", {2'b0, sel}, 8'h2F);
        check("t6_d4_seg", seg, 8'hA4);
        repeat (3) @(negedge sys_clk);
        check("t6_d5_sel", {2'b0, sel}, 8'h1F);
        check("t6_d5_seg", seg, 8'hF9);
        repeat (50) @(negedge sys_clk);
        scan_check("t6", 48'hFFFFFF909090);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
